knn_query_scheduler: RTL and testbench

- Front-end controller for the KNN classification core. Arbitrates between two query requesters using round-robin.
- For each granted query it drives the core's test vector and pulses the core's reset. It then waits the fixed core latency, captures final_class and c1..c5, and returns a result tagged with the requester ID over a valid/ready port.
- Replaces the manual reset / apply vector / wait sequence used around the core today.

---
 rtl/knn_query_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_knn_query_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_query_scheduler.sv
// knn_query_scheduler: front-end controller for the KNN classification core.
// Round-robin arbitration between two query requesters. Each granted query
// loads the core test vector, pulses the core reset, waits the fixed core
// latency, captures the voted class plus the five neighbour classes and
// returns them tagged with the requester ID over a valid/ready port.
// Optional build macro: KNN_SCHED_STATS_EN (completed-result counter on
// stat_count; tied to zero when undefined).
module knn_query_scheduler #(
    parameter int CORE_LATENCY = 150,
    parameter int RST_CYCLES   = 3,
    parameter int FEAT_W       = 16,
    parameter int CLASS_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [4*FEAT_W-1:0]  req0_vector,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [4*FEAT_W-1:0]  req1_vector,
    output logic                 req1_ready,
    output logic                 core_rst_n,
    output logic [4*FEAT_W-1:0]  core_vector,
    input  logic [CLASS_W-1:0]   core_c1,
    input  logic [CLASS_W-1:0]   core_c2,
    input  logic [CLASS_W-1:0]   core_c3,
    input  logic [CLASS_W-1:0]   core_c4,
    input  logic [CLASS_W-1:0]   core_c5,
    input  logic [CLASS_W-1:0]   core_final_class,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_id,
    output logic [CLASS_W-1:0]   res_class,
    output logic [5*CLASS_W-1:0] res_neighbors,
    output logic                 busy,
    output logic [15:0]          stat_count
);

    localparam int MAX_CNT = (CORE_LATENCY > RST_CYCLES) ? CORE_LATENCY : RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(CORE_LATENCY - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CORE_RST = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    logic [1:0]           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 last_grant_r;
    logic                 core_rst_n_r;
    logic [4*FEAT_W-1:0]  core_vector_r;
    logic                 res_valid_r;
    logic                 res_id_r;
    logic [CLASS_W-1:0]   res_class_r;
    logic [5*CLASS_W-1:0] res_neighbors_r;

    logic                 grant_s;
    logic                 req0_ready_s;
    logic                 req1_ready_s;
    logic                 accept_s;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant_s = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant_s = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Accept strobes: only in IDLE, only to the granted requester, never both.
    always_comb begin
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            req0_ready_s = ~grant_s & req0_valid;
            req1_ready_s =  grant_s & req1_valid;
        end else begin
            req0_ready_s = 1'b0;
            req1_ready_s = 1'b0;
        end
    end

    assign accept_s = req0_ready_s | req1_ready_s;

    // Query sequencer: accept, core reset pulse, fixed-latency wait, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            last_grant_r    <= 1'b1;
            core_rst_n_r    <= 1'b0;
            core_vector_r   <= {(4*FEAT_W){1'b0}};
            res_valid_r     <= 1'b0;
            res_id_r        <= 1'b0;
            res_class_r     <= {CLASS_W{1'b0}};
            res_neighbors_r <= {(5*CLASS_W){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    core_rst_n_r <= 1'b0;
                    if (accept_s) begin
                        core_vector_r <= grant_s ? req1_vector : req0_vector;
                        res_id_r      <= grant_s;
                        last_grant_r  <= grant_s;
                        cnt_r         <= {CNT_W{1'b0}};
                        state_r       <= ST_CORE_RST;
                    end
                end
                ST_CORE_RST: begin
                    if (cnt_r == RST_LAST) begin
                        cnt_r        <= {CNT_W{1'b0}};
                        core_rst_n_r <= 1'b1;
                        state_r      <= ST_RUN;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cnt_r == RUN_LAST) begin
                        res_class_r     <= core_final_class;
                        res_neighbors_r <= {core_c1, core_c2, core_c3, core_c4, core_c5};
                        res_valid_r     <= 1'b1;
                        state_r         <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_r  <= 1'b0;
                        core_rst_n_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_r  <= 1'b0;
                    core_rst_n_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef KNN_SCHED_STATS_EN
    logic [15:0] stat_count_r;

    // Completed-result counter, saturating; only the async reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count_r <= 16'h0000;
        end else if (res_valid_r && res_ready && (stat_count_r != 16'hFFFF)) begin
            stat_count_r <= stat_count_r + 16'h0001;
        end
    end

    assign stat_count = stat_count_r;
`else
    assign stat_count = 16'h0000;
`endif

    assign req0_ready    = req0_ready_s;
    assign req1_ready    = req1_ready_s;
    assign core_rst_n    = core_rst_n_r;
    assign core_vector   = core_vector_r;
    assign res_valid     = res_valid_r;
    assign res_id        = res_id_r;
    assign res_class     = res_class_r;
    assign res_neighbors = res_neighbors_r;
    assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_knn_query_scheduler.sv
// Directed bench for knn_query_scheduler. A small behavioural stand-in for
// the KNN core presents known classes for three known vectors only once the
// core has been out of reset for the full latency, and garbage before that.
module tb_knn_query_scheduler;

    localparam int CORE_LAT = 150;
    localparam int RST_CYC  = 3;
    localparam int LAT_EXP  = 153;

    localparam logic [63:0] VEC_A = 64'h0034_0024_000F_0003;
    localparam logic [63:0] VEC_B = 64'h0045_0021_002E_000F;
    localparam logic [63:0] VEC_C = 64'h0040_0022_003B_0018;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [63:0] req0_vector = 64'h0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [63:0] req1_vector = 64'h0;
    logic        req1_ready;
    logic        core_rst_n;
    logic [63:0] core_vector;
    logic [3:0]  core_c1, core_c2, core_c3, core_c4, core_c5, core_final_class;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_id;
    logic [3:0]  res_class;
    logic [19:0] res_neighbors;
    logic        busy;
    logic [15:0] stat_count;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int acc_edge = 0;
    int n_done = 0;
    int core_run_cnt = 0;
    logic [63:0] exp_vec = 64'h0;

    knn_query_scheduler #(.CORE_LATENCY(CORE_LAT), .RST_CYCLES(RST_CYC), .FEAT_W(16), .CLASS_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_vector(req0_vector), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_vector(req1_vector), .req1_ready(req1_ready),
        .core_rst_n(core_rst_n), .core_vector(core_vector),
        .core_c1(core_c1), .core_c2(core_c2), .core_c3(core_c3), .core_c4(core_c4), .core_c5(core_c5),
        .core_final_class(core_final_class),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_class(res_class), .res_neighbors(res_neighbors),
        .busy(busy), .stat_count(stat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Core stand-in: cycles since core reset release.
    always @(posedge clk) begin
        if (!core_rst_n) core_run_cnt <= 0;
        else             core_run_cnt <= core_run_cnt + 1;
    end

    // Core stand-in outputs: {final, c1..c5}; 4'hE everywhere until settled.
    always_comb begin
        logic [23:0] o;
        o = 24'hEEEEEE;
        if (core_rst_n && core_run_cnt >= CORE_LAT - 1) begin
            case (core_vector)
                VEC_A:   o = {4'h0, 20'h00010};
                VEC_B:   o = {4'h1, 20'h11211};
                VEC_C:   o = {4'h2, 20'h22212};
                default: o = {4'hF, 20'hFFFFF};
            endcase
        end
        core_final_class = o[23:20];
        core_c1 = o[19:16];
        core_c2 = o[15:12];
        core_c3 = o[11:8];
        core_c4 = o[7:4];
        core_c5 = o[3:0];
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] stat_exp(input int n);
`ifdef KNN_SCHED_STATS_EN
        return 16'(n);
`else
        return 16'h0000;
`endif
    endfunction

    // Present a query from requester id, wait for its accept, leave at the negedge after accept.
    task automatic issue(input bit id, input logic [63:0] vec, input bit keep);
        int t;
        if (id) begin req1_vector = vec; req1_valid = 1'b1; end
        else    begin req0_vector = vec; req0_valid = 1'b1; end
        exp_vec = vec;
        #1;
        t = 0;
        while (!(id ? req1_ready : req0_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_val("ready_delay", 64'(t), 64'd0);
        check_val("other_ready", id ? req0_ready : req1_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        acc_edge = edge_cnt;
        check_val("busy_after_accept", busy, 1'b1);
        check_val("core_vector_load", core_vector, vec);
        if (!keep) begin
            if (id) req1_valid = 1'b0;
            else    req0_valid = 1'b0;
        end
    endtask

    // Wait for res_valid (bounded); reports latency and whether core_vector held.
    task automatic wait_result(output int lat, output bit vec_ok);
        int t;
        t = 0;
        vec_ok = 1'b1;
        while (!res_valid && t < 400) begin
            if (core_vector !== exp_vec) vec_ok = 1'b0;
            @(negedge clk);
            t++;
        end
        check_val("res_timeout", res_valid, 1'b1);
        lat = edge_cnt - acc_edge;
    endtask

    task automatic expect_result(input bit id, input logic [3:0] cls, input logic [19:0] nb);
        int lat;
        bit vec_ok;
        wait_result(lat, vec_ok);
        check_val("latency", 64'(lat), 64'(LAT_EXP));
        check_val("core_vector_hold", vec_ok, 1'b1);
        check_val("res_id", res_id, id);
        check_val("res_class", res_class, cls);
        check_val("res_neighbors", res_neighbors, nb);
        if (res_ready) begin
            @(negedge clk);
            n_done++;
            check_val("res_valid_drop", res_valid, 1'b0);
            check_val("busy_after_hs", busy, 1'b0);
            check_val("stat_count", stat_count, stat_exp(n_done));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_done = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit stable;
        bit no_pulse;
        logic [3:0] s_cls;
        logic [19:0] s_nb;
        logic s_id;

        // Reset values.
        repeat (2) @(negedge clk);
        check_val("rst_core_rst_n", core_rst_n, 1'b0);
        check_val("rst_core_vector", core_vector, 64'h0);
        check_val("rst_res_valid", res_valid, 1'b0);
        check_val("rst_res_out", {res_id, res_class, res_neighbors}, 25'h0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_stat", stat_count, 16'h0);
        do_reset();

        // Single query.
        res_ready = 1'b1;
        issue(1'b0, VEC_A, 1'b0);
        n = 0;
        while (core_rst_n == 1'b0 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check_val("core_rst_len", 64'(n), 64'(RST_CYC));
        expect_result(1'b0, 4'h0, 20'h00010);

        // Contention: fresh reset so requester 0 wins the first tie.
        do_reset();
        req0_vector = VEC_B; req0_valid = 1'b1;
        req1_vector = VEC_C; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                issue(1'b0, VEC_B, 1'b1);
                expect_result(1'b0, 4'h1, 20'h11211);
            end else begin
                issue(1'b1, VEC_C, 1'b1);
                expect_result(1'b1, 4'h2, 20'h22212);
            end
        end

        // Backpressure: both still requesting, consumer stalls 40 cycles.
        res_ready = 1'b0;
        req0_vector = VEC_A;
        issue(1'b0, VEC_A, 1'b1);
        expect_result(1'b0, 4'h0, 20'h00010);
        s_id = res_id; s_cls = res_class; s_nb = res_neighbors;
        stable = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!res_valid || res_id !== s_id || res_class !== s_cls || res_neighbors !== s_nb ||
                req0_ready || req1_ready) stable = 1'b0;
        end
        check_val("bp_stable", stable, 1'b1);
        res_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        n_done++;
        check_val("bp_res_valid_drop", res_valid, 1'b0);
        check_val("bp_busy", busy, 1'b0);
        check_val("bp_stat", stat_count, stat_exp(n_done));

        // Late input change: vector swapped the cycle after accept.
        issue(1'b0, VEC_A, 1'b0);
        req0_vector = VEC_B;
        expect_result(1'b0, 4'h0, 20'h00010);

        // Mid-run reset at RUN counter 70.
        issue(1'b0, VEC_A, 1'b0);
        repeat (RST_CYC + 70) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_core_rst_n", core_rst_n, 1'b0);
        check_val("mid_core_vector", core_vector, 64'h0);
        check_val("mid_busy", busy, 1'b0);
        check_val("mid_res", {res_valid, res_id, res_class, res_neighbors}, 26'h0);
        check_val("mid_stat", stat_count, 16'h0);
        n_done = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        no_pulse = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (res_valid || busy) no_pulse = 1'b0;
        end
        check_val("mid_no_result", no_pulse, 1'b1);

        // Five complete queries after the abort.
        issue(1'b0, VEC_A, 1'b0);
        expect_result(1'b0, 4'h0, 20'h00010);
        issue(1'b1, VEC_C, 1'b0);
        expect_result(1'b1, 4'h2, 20'h22212);
        issue(1'b0, VEC_B, 1'b0);
        expect_result(1'b0, 4'h1, 20'h11211);
        issue(1'b1, VEC_B, 1'b0);
        expect_result(1'b1, 4'h1, 20'h11211);
        issue(1'b0, VEC_C, 1'b0);
        expect_result(1'b0, 4'h2, 20'h22212);
        check_val("stat_final", stat_count, stat_exp(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
